// File: rtl/vertex_pkg.sv
// Shared constants and FSM encoding for the triangle vertex fetcher.
package vertex_pkg;

  localparam int unsigned VERTS_PER_TRI  = 3;
  localparam int unsigned WORDS_PER_TRI  = 2 * VERTS_PER_TRI;
  localparam int unsigned WORD_CNT_WIDTH = 3;
  localparam int unsigned TRI_IDX_WIDTH  = 8;

  // ROM word order within one triangle record
  localparam logic [WORD_CNT_WIDTH-1:0] SLOT_X0 = 3'd0;
  localparam logic [WORD_CNT_WIDTH-1:0] SLOT_Y0 = 3'd1;
  localparam logic [WORD_CNT_WIDTH-1:0] SLOT_X1 = 3'd2;
  localparam logic [WORD_CNT_WIDTH-1:0] SLOT_Y1 = 3'd3;
  localparam logic [WORD_CNT_WIDTH-1:0] SLOT_X2 = 3'd4;
  localparam logic [WORD_CNT_WIDTH-1:0] SLOT_Y2 = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/vertex_addr_gen.sv
// Word/triangle counters and registered ROM address for the vertex fetcher.
module vertex_addr_gen
  import vertex_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned NUM_TRIANGLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      step,
  input  logic                      advance,
  output logic [WORD_CNT_WIDTH-1:0] word_cnt,
  output logic [TRI_IDX_WIDTH-1:0]  tri_index,
  output logic                      last_word_c,
  output logic                      last_tri_c,
  output logic [ADDR_WIDTH-1:0]     rom_addr
);

  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(WORDS_PER_TRI);

  // First-word address of the triangle being fetched
  logic [ADDR_WIDTH-1:0] tri_base;

  assign last_word_c = (word_cnt == WORD_CNT_WIDTH'(WORDS_PER_TRI - 1));
  assign last_tri_c  = (tri_index == TRI_IDX_WIDTH'(NUM_TRIANGLES - 1));

  // rom_addr is kept one step ahead so it is valid during every FETCH cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt  <= '0;
      tri_index <= '0;
      tri_base  <= BASE_A;
      rom_addr  <= BASE_A;
    end else if (clear) begin
      word_cnt  <= '0;
      tri_index <= '0;
      tri_base  <= BASE_A;
      rom_addr  <= BASE_A;
    end else if (advance) begin
      word_cnt  <= '0;
      tri_index <= tri_index + TRI_IDX_WIDTH'(1);
      tri_base  <= tri_base + STRIDE;
      rom_addr  <= tri_base + STRIDE;
    end else if (step) begin
      if (last_word_c) begin
        rom_addr <= BASE_A;
      end else begin
        word_cnt <= word_cnt + WORD_CNT_WIDTH'(1);
        rom_addr <= rom_addr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/triangle_vertex_fetcher.sv
// Walks the vertex ROM, assembles one triangle at a time and presents it
// to the rasterizer over a valid/ready handshake.
module triangle_vertex_fetcher
  import vertex_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned COORD_WIDTH   = 10,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned NUM_TRIANGLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic [ADDR_WIDTH-1:0]    rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic                     tri_valid,
  input  logic                     tri_ready,
  output logic [COORD_WIDTH-1:0]   x0,
  output logic [COORD_WIDTH-1:0]   y0,
  output logic [COORD_WIDTH-1:0]   x1,
  output logic [COORD_WIDTH-1:0]   y1,
  output logic [COORD_WIDTH-1:0]   x2,
  output logic [COORD_WIDTH-1:0]   y2,
  output logic [TRI_IDX_WIDTH-1:0] tri_index,
  output logic                     coord_clip,
  output logic                     done
);

  localparam longint unsigned LAST_ADDR =
    longint'(BASE_ADDR) + longint'(WORDS_PER_TRI) * longint'(NUM_TRIANGLES) - 1;

  if (NUM_TRIANGLES < 1) begin : g_chk_num
    $error("triangle_vertex_fetcher: NUM_TRIANGLES must be >= 1");
  end
  if (NUM_TRIANGLES > (1 << TRI_IDX_WIDTH)) begin : g_chk_idx
    $error("triangle_vertex_fetcher: NUM_TRIANGLES exceeds tri_index range");
  end
  if (LAST_ADDR >= (64'd1 << ADDR_WIDTH)) begin : g_chk_addr
    $error("triangle_vertex_fetcher: triangle records exceed ROM address range");
  end
  if (COORD_WIDTH >= DATA_WIDTH) begin : g_chk_coord
    $error("triangle_vertex_fetcher: COORD_WIDTH must be below DATA_WIDTH");
  end

  state_t                    state;
  state_t                    next_state;
  logic                      clear_c;
  logic                      step_c;
  logic                      advance_c;
  logic                      last_word_c;
  logic                      last_tri_c;
  logic [WORD_CNT_WIDTH-1:0] word_cnt;

  vertex_addr_gen #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .BASE_ADDR     (BASE_ADDR),
    .NUM_TRIANGLES (NUM_TRIANGLES)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear_c),
    .step        (step_c),
    .advance     (advance_c),
    .word_cnt    (word_cnt),
    .tri_index   (tri_index),
    .last_word_c (last_word_c),
    .last_tri_c  (last_tri_c),
    .rom_addr    (rom_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    clear_c    = 1'b0;
    step_c     = 1'b0;
    advance_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = FETCH;
          clear_c    = 1'b1;
        end
      end
      FETCH: begin
        step_c = 1'b1;
        if (last_word_c) next_state = PRESENT;
      end
      PRESENT: begin
        if (tri_ready) begin
          if (last_tri_c) begin
            next_state = DONE;
          end else begin
            next_state = FETCH;
            advance_c  = 1'b1;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs follow the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      tri_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy      <= (next_state != IDLE);
      tri_valid <= (next_state == PRESENT);
      done      <= (next_state == DONE);
    end
  end

  // Slot capture and sticky clip flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0         <= '0;
      y0         <= '0;
      x1         <= '0;
      y1         <= '0;
      x2         <= '0;
      y2         <= '0;
      coord_clip <= 1'b0;
    end else if (clear_c) begin
      coord_clip <= 1'b0;
    end else if (step_c) begin
      case (word_cnt)
        SLOT_X0: x0 <= rom_data[COORD_WIDTH-1:0];
        SLOT_Y0: y0 <= rom_data[COORD_WIDTH-1:0];
        SLOT_X1: x1 <= rom_data[COORD_WIDTH-1:0];
        SLOT_Y1: y1 <= rom_data[COORD_WIDTH-1:0];
        SLOT_X2: x2 <= rom_data[COORD_WIDTH-1:0];
        SLOT_Y2: y2 <= rom_data[COORD_WIDTH-1:0];
        default: ;
      endcase
      if ((rom_data >> COORD_WIDTH) != '0) coord_clip <= 1'b1;
    end
  end

endmodule

// File: tb/tb_triangle_vertex_fetcher.sv
// Bench for triangle_vertex_fetcher: one 1-triangle and one 2-triangle instance.
module tb_triangle_vertex_fetcher;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Instance 1: NUM_TRIANGLES=1
  logic        start1, ready1, busy1, valid1, clip1, done1;
  logic [7:0]  addr1, idx1;
  logic [31:0] data1;
  logic [9:0]  c1 [6];
  logic [31:0] rom1 [256];
  assign data1 = rom1[addr1];

  // Instance 2: NUM_TRIANGLES=2
  logic        start2, ready2, busy2, valid2, clip2, done2;
  logic [7:0]  addr2, idx2;
  logic [31:0] data2;
  logic [9:0]  c2 [6];
  logic [31:0] rom2 [256];
  assign data2 = rom2[addr2];

  triangle_vertex_fetcher #(.NUM_TRIANGLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .rom_addr(addr1),
    .rom_data(data1), .tri_valid(valid1), .tri_ready(ready1),
    .x0(c1[0]), .y0(c1[1]), .x1(c1[2]), .y1(c1[3]), .x2(c1[4]), .y2(c1[5]),
    .tri_index(idx1), .coord_clip(clip1), .done(done1)
  );

  triangle_vertex_fetcher #(.NUM_TRIANGLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .rom_addr(addr2),
    .rom_data(data2), .tri_valid(valid2), .tri_ready(ready2),
    .x0(c2[0]), .y0(c2[1]), .x1(c2[2]), .y1(c2[3]), .x2(c2[4]), .y2(c2[5]),
    .tri_index(idx2), .coord_clip(clip2), .done(done2)
  );

  typedef struct {
    bit         start;
    bit         ready;
    bit         e_busy;
    bit         e_valid;
    bit         e_done;
    logic [7:0] e_addr;
  } vec_t;

  int exp_tri [6] = '{10, 20, 35, 40, 30, 60};

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: triangle t is six consecutive ROM words, truncated to 10 bits
  function automatic logic [9:0] ref_coord2(input int t, input int k);
    logic [31:0] w;
    w = rom2[t * 6 + k];
    return w[9:0];
  endfunction

  function automatic bit ref_clip2();
    bit c = 1'b0;
    for (int i = 0; i < 12; i++) if ((rom2[i] >> 10) != 0) c = 1'b1;
    return c;
  endfunction

  task automatic check_coords1(input string name, input int e0);
    for (int k = 0; k < 6; k++) chk($sformatf("%s_c%0d", name, k), c1[k], (k == 0) ? e0 : exp_tri[k]);
  endtask

  task automatic wait_valid1(input string name, output int n);
    n = 0;
    while (!valid1 && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_valid_seen"}, valid1, 1);
  endtask

  task automatic drain1(input string name);
    int n = 0;
    ready1 = 1'b1;
    while (busy1 && n < 30) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, busy1, 0);
  endtask

  // Full run on instance 2, checked against the reference
  task automatic run2(input string name, input bit rnd);
    logic [7:0] got [$];
    int acc   = 0;
    int dones = 0;
    int cyc   = 0;
    bit fin   = 1'b0;
    ready2 = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk({name, "_busy"}, busy2, 1);
    chk({name, "_clip_cleared"}, clip2, 0);
    while (!fin && cyc < 400) begin
      if (busy2 && !valid2 && !done2) got.push_back(addr2);
      if (valid2) begin
        if (acc < 2) begin
          for (int k = 0; k < 6; k++) chk($sformatf("%s_t%0d_c%0d", name, acc, k), c2[k], ref_coord2(acc, k));
          chk({name, "_index"}, idx2, acc);
          chk({name, "_addr_present"}, addr2, 0);
        end else begin
          chk({name, "_extra_triangle"}, acc, 1);
        end
      end
      if (done2) begin
        dones++;
        chk({name, "_done_after_last"}, acc, 2);
      end
      ready2 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start2 = (rnd && !done2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (valid2 && ready2) acc++;
      tick();
      cyc++;
      if (!busy2) fin = 1'b1;
    end
    start2 = 1'b0;
    chk({name, "_finished"}, fin, 1);
    chk({name, "_done_count"}, dones, 1);
    chk({name, "_accepted"}, acc, 2);
    chk({name, "_addr_count"}, got.size(), 12);
    for (int i = 0; i < got.size() && i < 12; i++) chk($sformatf("%s_addr%0d", name, i), got[i], i);
    chk({name, "_clip"}, clip2, ref_clip2());
    for (int k = 0; k < 6; k++) chk($sformatf("%s_hold_c%0d", name, k), c2[k], ref_coord2(1, k));
  endtask

  initial begin
    vec_t t1 [9];
    int   n;

    for (int i = 0; i < 256; i++) begin
      rom1[i] = 32'd0;
      rom2[i] = 32'd0;
    end
    for (int i = 0; i < 6; i++) begin
      rom1[i] = 32'(exp_tri[i]);
      rom2[i] = 32'(exp_tri[i]);
    end

    t1[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    t1[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    t1[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    t1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
    t1[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4};
    t1[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5};
    t1[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    t1[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
    t1[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

    rst    = 1'b1;
    start1 = 1'b0; ready1 = 1'b0;
    start2 = 1'b0; ready2 = 1'b0;
    #12;
    chk("rst_busy", busy1, 0);
    chk("rst_valid", valid1, 0);
    chk("rst_done", done1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_index", idx1, 0);
    chk("rst_clip", clip1, 0);
    chk("rst_x0", c1[0], 0);
    chk("rst_busy2", busy2, 0);
    rst = 1'b0;
    tick();

    // Basic run, cycle by cycle
    for (int i = 0; i < 9; i++) begin
      start1 = t1[i].start;
      ready1 = t1[i].ready;
      tick();
      chk($sformatf("t1_busy_e%0d", i + 1), busy1, t1[i].e_busy);
      chk($sformatf("t1_valid_e%0d", i + 1), valid1, t1[i].e_valid);
      chk($sformatf("t1_done_e%0d", i + 1), done1, t1[i].e_done);
      chk($sformatf("t1_addr_e%0d", i + 1), addr1, t1[i].e_addr);
      if (t1[i].e_valid) begin
        check_coords1("t1", 10);
        chk("t1_index", idx1, 0);
      end
    end
    check_coords1("t1_hold", 10);

    // Back-pressure in PRESENT
    ready1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_valid1("t2", n);
    chk("t2_latency", n, 6);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_valid_held", valid1, 1);
      chk("t2_addr_base", addr1, 0);
      check_coords1("t2_held", 10);
    end
    ready1 = 1'b1;
    tick();
    chk("t2_valid_drop", valid1, 0);
    chk("t2_done", done1, 1);
    tick();
    chk("t2_done_pulse", done1, 0);
    chk("t2_idle", busy1, 0);

    // start while busy is ignored
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("t4_addr_no_restart", addr1, 2);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_valid", valid1, 1);
    ready1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("t4_present_held", valid1, 1);
    chk("t4_present_addr", addr1, 0);
    chk("t4_present_index", idx1, 0);
    drain1("t4");

    // Asynchronous reset in the middle of FETCH
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t4_rst_busy", busy1, 0);
    chk("t4_rst_addr", addr1, 0);
    chk("t4_rst_valid", valid1, 0);
    chk("t4_rst_x0", c1[0], 0);
    chk("t4_rst_y2", c1[5], 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t4_rst_stays_idle", busy1, 0);

    // Clip detection and clearing on the next start
    rom1[0] = 32'h0000_0400;
    ready1  = 1'b0;
    start1  = 1'b1;
    tick();
    start1 = 1'b0;
    wait_valid1("t5", n);
    check_coords1("t5", 0);
    chk("t5_clip", clip1, 1);
    drain1("t5");
    chk("t5_clip_sticky", clip1, 1);
    rom1[0] = 32'd10;
    start1  = 1'b1;
    tick();
    start1 = 1'b0;
    chk("t5_clip_cleared", clip1, 0);
    drain1("t5b");
    chk("t5b_clip", clip1, 0);
    check_coords1("t5b", 10);

    // Two triangles, fixed ROM, then randomized ROM and handshake
    run2("t3", 1'b0);
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 12; i++)
        rom2[i] = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
      run2($sformatf("rnd%0d", r), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
